// File: rtl/imul_scheduler.sv
// Multiplier issue scheduler: 2-way arbiter, tag pipe, credit-managed result FIFO.
// IMUL_SCHED_RR_EN selects round-robin arbitration; IMUL_LATENCY sets default depth.
`ifndef IMUL_LATENCY
`define IMUL_LATENCY 5
`endif

module imul_scheduler #(
    parameter int LATENCY   = `IMUL_LATENCY,
    parameter int TAG_W     = 6,
    parameter int BUF_DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [2*TAG_W-1:0] req_tag,
    output logic [1:0]         req_ready,
    input  logic               flush,
    output logic               mul_ce,
    output logic               mul_sel,
    input  logic [31:0]        mul_result,
    output logic               wb_valid,
    output logic [TAG_W-1:0]   wb_tag,
    output logic [31:0]        wb_data,
    input  logic               wb_ready
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);
    localparam logic [CW-1:0] ALL_CR = CW'(BUF_DEPTH);

    logic [CW-1:0]    credits;
    logic [CW-1:0]    count;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [TAG_W-1:0] buf_tag [BUF_DEPTH];
    logic [31:0]      buf_data [BUF_DEPTH];
    logic [LATENCY-1:0] pipe_v;
    logic [TAG_W-1:0] pipe_tag [LATENCY];

    logic             grant_sel;
    logic             can_issue;
    logic             accept;
    logic             push;
    logic             pop;
    logic [TAG_W-1:0] acc_tag;

`ifdef IMUL_SCHED_RR_EN
    logic rr_ptr;

    always_comb begin
        grant_sel = ~req_valid[0];
        if (req_valid == 2'b11)
            grant_sel = rr_ptr;
    end

    // Pointer hands priority to the requester that just lost.
    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (accept)
            rr_ptr <= ~grant_sel;
    end
`else
    assign grant_sel = ~req_valid[0];
`endif

    assign can_issue = !reset && !flush && (credits != '0);

    always_comb begin
        req_ready    = 2'b00;
        req_ready[0] = can_issue & req_valid[0] & ~grant_sel;
        req_ready[1] = can_issue & req_valid[1] & grant_sel;
    end

    assign accept  = |req_ready;
    assign mul_ce  = accept;
    assign mul_sel = accept & grant_sel;
    assign acc_tag = grant_sel ? req_tag[2*TAG_W-1:TAG_W]
                               : req_tag[TAG_W-1:0];

    assign push     = pipe_v[LATENCY-1];
    assign wb_valid = !reset && (count != '0);
    assign pop      = wb_valid & wb_ready & ~flush;
    assign wb_tag   = wb_valid ? buf_tag[head] : '0;
    assign wb_data  = wb_valid ? buf_data[head] : '0;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            pipe_v  <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            credits <= ALL_CR;
        end else begin
            pipe_v[0] <= accept;
            for (int i = 1; i < LATENCY; i++)
                pipe_v[i] <= pipe_v[i-1];
            if (push)
                tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
            if (pop)
                head <= (head == LAST_IDX) ? '0 : head + 1'b1;
            count   <= count + CW'(push) - CW'(pop);
            credits <= credits - CW'(accept) + CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        pipe_tag[0] <= acc_tag;
        for (int i = 1; i < LATENCY; i++)
            pipe_tag[i] <= pipe_tag[i-1];
        if (push && !reset && !flush) begin
            buf_tag[tail]  <= pipe_tag[LATENCY-1];
            buf_data[tail] <= mul_result;
        end
    end

endmodule

// File: tb/tb_imul_scheduler.sv
// Directed bench for imul_scheduler with a behavioural fixed-latency multiplier.
module tb_imul_scheduler;

    localparam int LAT = 5;
    localparam int BD  = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [11:0] req_tag;
    logic [1:0]  req_ready;
    logic        flush;
    logic        mul_ce;
    logic        mul_sel;
    logic [31:0] mul_result;
    logic        wb_valid;
    logic [5:0]  wb_tag;
    logic [31:0] wb_data;
    logic        wb_ready;

    int pass_cnt = 0;
    int total = 0;
    int wb_seen = 0;
    logic [37:0] popped [$];

    logic [LAT-1:0] hv = '0;
    logic [5:0]     ht [LAT];

    imul_scheduler dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_tag(req_tag),
        .req_ready(req_ready), .flush(flush),
        .mul_ce(mul_ce), .mul_sel(mul_sel),
        .mul_result(mul_result), .wb_valid(wb_valid),
        .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_ready(wb_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        hv <= {hv[LAT-2:0], mul_ce};
        ht[0] <= mul_sel ? req_tag[11:6] : req_tag[5:0];
        for (int i = 1; i < LAT; i++)
            ht[i] <= ht[i-1];
    end

    assign mul_result = hv[LAT-1] ? (32'hC0DE0000 | 32'(ht[LAT-1]))
                                  : 32'hDEADBEEF;

    always @(posedge clock) begin
        if (wb_valid)
            wb_seen <= wb_seen + 1;
        if (wb_valid && wb_ready && !flush && !reset)
            popped.push_back({wb_tag, wb_data});
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        flush = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b11;
        req_tag = 12'h0C3;
        flush = 1'b0;
        wb_ready = 1'b1;
        step();
        step();
        #1;
        total++;
        if (req_ready !== 2'b00)
            $display("FAIL reset_ready got %b want 00", req_ready);
        else pass_cnt++;
        total++;
        if (mul_ce !== 1'b0)
            $display("FAIL reset_ce got %b want 0", mul_ce);
        else pass_cnt++;
        total++;
        if (mul_sel !== 1'b0)
            $display("FAIL reset_sel got %b want 0", mul_sel);
        else pass_cnt++;
        total++;
        if (wb_valid !== 1'b0)
            $display("FAIL reset_wbv got %b want 0", wb_valid);
        else pass_cnt++;
        total++;
        if (wb_tag !== 6'h00)
            $display("FAIL reset_tag got %h want 00", wb_tag);
        else pass_cnt++;
        total++;
        if (wb_data !== 32'h0)
            $display("FAIL reset_data got %h want 0", wb_data);
        else pass_cnt++;
        req_valid = 2'b00;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        int c;
        wb_ready = 1'b1;
        req_valid = 2'b01;
        req_tag = 12'h005;
        #1;
        total++;
        if (mul_ce !== 1'b1 || mul_sel !== 1'b0 || req_ready !== 2'b01)
            $display("FAIL single_issue got ce=%b sel=%b rdy=%b want 1 0 01",
                     mul_ce, mul_sel, req_ready);
        else pass_cnt++;
        c = 0;
        step();
        req_valid = 2'b00;
        while (!wb_valid && c < 20) begin
            step();
            c++;
        end
        c++;
        total++;
        if (c !== LAT + 1)
            $display("FAIL single_latency got %0d want %0d", c, LAT + 1);
        else pass_cnt++;
        total++;
        if (wb_tag !== 6'h05 || wb_data !== 32'hC0DE0005)
            $display("FAIL single_result got %h/%h want 05/c0de0005",
                     wb_tag, wb_data);
        else pass_cnt++;
        step();
        total++;
        if (wb_valid !== 1'b0)
            $display("FAIL single_onecycle got %b want 0", wb_valid);
        else pass_cnt++;
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_rdy;
        logic [5:0] exp_tag;
        do_reset();
        wb_ready = 1'b1;
        popped.delete();
        req_valid = 2'b11;
        req_tag = {6'h02, 6'h01};
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef IMUL_SCHED_RR_EN
            exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_rdy = 2'b01;
`endif
            total++;
            if (req_ready !== exp_rdy)
                $display("FAIL arb_grant%0d got %b want %b",
                         i, req_ready, exp_rdy);
            else pass_cnt++;
            step();
        end
        req_valid = 2'b00;
        repeat (12) step();
        total++;
        if (popped.size() !== 4)
            $display("FAIL arb_count got %0d want 4", popped.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < popped.size(); i++) begin
`ifdef IMUL_SCHED_RR_EN
            exp_tag = (i % 2 == 1) ? 6'h02 : 6'h01;
`else
            exp_tag = 6'h01;
`endif
            total++;
            if (popped[i] !== {exp_tag, 32'hC0DE0000 | 32'(exp_tag)})
                $display("FAIL arb_wb%0d got %h want tag %h",
                         i, popped[i], exp_tag);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int acc_hi;
        logic [5:0] t;
        do_reset();
        popped.delete();
        wb_ready = 1'b0;
        n = 0;
        req_valid = 2'b01;
        for (int i = 0; i < 16; i++) begin
            req_tag = {6'h00, 6'(6'h10 + n)};
            #1;
            if (mul_ce) n++;
            step();
        end
        total++;
        if (n !== BD)
            $display("FAIL bp_accepts got %0d want %0d", n, BD);
        else pass_cnt++;
        req_tag = {6'h00, 6'(6'h10 + n)};
        #1;
        total++;
        if (req_ready !== 2'b00)
            $display("FAIL bp_stall got %b want 00", req_ready);
        else pass_cnt++;
        total++;
        if (wb_valid !== 1'b1 || wb_tag !== 6'h10)
            $display("FAIL bp_head got %b/%h want 1/10", wb_valid, wb_tag);
        else pass_cnt++;
        wb_ready = 1'b1;
        acc_hi = n;
        for (int i = 0; i < 20; i++) begin
            req_tag = {6'h00, 6'(6'h10 + n)};
            #1;
            if (mul_ce) n++;
            step();
        end
        total++;
        if (n - acc_hi !== 19)
            $display("FAIL bp_throughput got %0d want 19", n - acc_hi);
        else pass_cnt++;
        req_valid = 2'b00;
        repeat (16) step();
        total++;
        if (popped.size() !== BD + 19)
            $display("FAIL bp_pops got %0d want %0d", popped.size(), BD + 19);
        else pass_cnt++;
        for (int i = 0; i < popped.size(); i++) begin
            t = 6'(6'h10 + i);
            total++;
            if (popped[i] !== {t, 32'hC0DE0000 | 32'(t)})
                $display("FAIL bp_order%0d got %h want tag %h",
                         i, popped[i], t);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        int n;
        int seen0;
        do_reset();
        wb_ready = 1'b1;
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_tag = {6'h00, 6'(6'h31 + i)};
            step();
        end
        req_valid = 2'b00;
        step();
        seen0 = wb_seen;
        flush = 1'b1;
        req_valid = 2'b01;
        req_tag = 12'h03F;
        #1;
        total++;
        if (req_ready !== 2'b00 || mul_ce !== 1'b0)
            $display("FAIL flush_grant got rdy=%b ce=%b want 00 0",
                     req_ready, mul_ce);
        else pass_cnt++;
        step();
        flush = 1'b0;
        req_valid = 2'b00;
        total++;
        if (wb_valid !== 1'b0)
            $display("FAIL flush_wbv got %b want 0", wb_valid);
        else pass_cnt++;
        wb_ready = 1'b0;
        n = 0;
        req_valid = 2'b01;
        req_tag = 12'h001;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (mul_ce) n++;
            if (wb_valid && wb_tag >= 6'h31 && wb_tag <= 6'h33) n += 100;
            step();
        end
        total++;
        if (n !== BD)
            $display("FAIL flush_credits got %0d want %0d", n, BD);
        else pass_cnt++;
        total++;
        if (wb_seen - seen0 > 0 && popped.size() > 0 &&
            popped[popped.size()-1][37:32] inside {6'h31, 6'h32, 6'h33})
            $display("FAIL flush_killed got tag %h want none",
                     popped[popped.size()-1][37:32]);
        else pass_cnt++;
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        int seen0;
        do_reset();
        wb_ready = 1'b1;
        req_valid = 2'b01;
        req_tag = 12'h03A;
        step();
        req_tag = 12'h03B;
        step();
        req_valid = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        seen0 = wb_seen;
        repeat (12) step();
        total++;
        if (wb_seen !== seen0)
            $display("FAIL reset_mid got %0d wb cycles want 0",
                     wb_seen - seen0);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        req_tag = '0;
        flush = 1'b0;
        wb_ready = 1'b0;
        test_reset();
        test_single();
        test_arbitration();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
